peridot_spiflash_byte_master: RTL and testbench
===============================================

// Module: peridot_spiflash_byte_master
// PURPOSE
//  Byte-wide SPI master that sits directly downstream of the host bridge CSR block and drives the boot SPI-Flash (EPCS/EPCQ) pins.
//  It receives the bridge's start/select/txdata writes, shifts one byte out on MOSI while capturing one byte from MISO, and reports ready and rxdata back.
//  Bit order, SPI mode and SCLK divider are runtime registers; the parameters give their reset values.
// PARAMETERS
//  DEFAULT_REG_BITRVS  0  reset value of bitrvs (0 = MSB first, 1 = LSB first)
//  DEFAULT_REG_MODE    0  reset SPI mode 0..3 ({CPOL,CPHA})
//  DEFAULT_REG_CLKDIV  0  reset divider N (0..255); SCLK half-period = N+1 clocks
// PORTS
//  csi_clk        in   1   single clock; all logic on its rising edge
//  rsi_reset_n    in   1   reset, asynchronous, active-low
//  avs_address    in   1   0 = data/control reg, 1 = config reg
//  avs_read       in   1   read strobe (read has no side effects)
//  avs_readdata   out  32  combinational read data
//  avs_write      in   1   write strobe
//  avs_writedata  in   32  write data
//  ins_irq        out  1   irqena & ready
//  spi_ss_n       out  1   chip select, = ~select
//  spi_sclk       out  1   serial clock
//  spi_mosi       out  1   serial data out
//  spi_miso       in   1   serial data in
// BEHAVIOUR
//  reg0 read:  {16'b0, irqena, 5'b0, ready, select, rxdata[7:0]}
//  reg0 write: bit15 irqena, bit9 start, bit8 select, bit7-0 txdata
//  reg1 r/w:   bit15 bitrvs, bits13-12 mode, bits7-0 clkdiv; other bits read 0
//  Reset values: ready=1, select=0 (spi_ss_n=1), irqena=0, rxdata=0, spi_mosi=0, spi_sclk=DEFAULT_REG_MODE[1], ins_irq=0.
//  FSM states: IDLE, XFER.
//   IDLE: ready=1; spi_sclk=CPOL.
//    A reg0 write latches irqena and select.
//    If bit9=1 in the same write: load txdata into the shift register (bit-reversed when bitrvs=1), reload divider, edge count=0, ready<=0, go to XFER.
//    With CPHA=0, spi_mosi presents the first bit in the cycle after the write.
//   XFER: divider counts N..0; on each expiry spi_sclk toggles and the edge count increments.
//    Each byte has 16 edges, alternating leading (odd) and trailing (even).
//    CPHA=0: sample MISO on leading edges, shift MOSI on trailing edges.
//    CPHA=1: shift MOSI on leading edges, sample MISO on trailing edges.
//    After edge 16: rxdata <= captured byte (in the same bit order as tx), ready<=1, return to IDLE.
//    SCLK is back at CPOL when the FSM reaches IDLE.
//   Latency: ready re-asserts exactly 16*(N+1) clocks after the start-write cycle.
//  While in XFER, all writes to reg0 and reg1 are ignored, including select, irqena and config. This keeps SS and timing stable mid-byte.
//  In IDLE, a reg1 write takes effect at once: spi_sclk snaps to the new CPOL in the next cycle; clkdiv applies to the next byte.
//  Write with bit9=0 in IDLE: updates only select/irqena/txdata; no transfer starts.
//  Chip select is never altered by the FSM; the host holds it across multi-byte commands.
//  reset_n asserted mid-transfer: everything returns to reset values asynchronously; the partial byte is discarded.
//  ins_irq is a level; it clears via irqena=0 or by starting a new transfer.
// TESTING
//  1. Mode0, N=0, MISO looped to MOSI, write reg0=0x0000_03A5 -> ss_n=0; 8 SCLK pulses; MOSI 1,0,1,0,0,1,0,1; ready=0 for 16 clocks; then reg0 reads 0x0000_03A5.
//  2. Mode3, N=3, idle SCLK=1; MISO driven with 0x3C, tx 0xFF -> 16*4=64 clocks busy; rxdata=0x3C; SCLK ends high.
//  3. bitrvs=1, tx 0x01, loopback -> first MOSI bit is 1 and the following seven are 0; rxdata reads 0x01.
//  4. While busy, write reg0=0x0000_0000 and reg1=0x0000_3000 -> select stays 1, mode unchanged, transfer completes normally.
//  5. irqena=1 with a transfer -> ins_irq=0 during XFER, 1 after completion; a write of irqena=0 drops it next cycle.
//  6. Assert rsi_reset_n low at clock 5 of a transfer -> ss_n=1, ready=1, SCLK=CPOL, rxdata=0 immediately.

Source files
------------

// File: rtl/peridot_spiflash_byte_master.sv
// Byte-wide SPI master for the boot SPI-Flash: one CSR-triggered byte exchange
// at a time, with runtime bit order, SPI mode and SCLK divider.
module peridot_spiflash_byte_master #(
    parameter bit         DEFAULT_REG_BITRVS = 1'b0,
    parameter logic [1:0] DEFAULT_REG_MODE   = 2'd0,
    parameter logic [7:0] DEFAULT_REG_CLKDIV = 8'd0
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    output logic        spi_ss_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q;
    logic        ready_q, select_q, irqena_q, bitrvs_q;
    logic [1:0]  mode_q;
    logic [7:0]  clkdiv_q, rxdata_q, div_q, tx_q, rx_q;
    logic [4:0]  edge_q;
    logic        sclk_q, mosi_q;

    logic        wr0, wr1, sample_edge;
    logic [4:0]  edge_d;
    logic [7:0]  tx_load, rx_shift, rx_final;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign wr0         = avs_write & ~avs_address;
    assign wr1         = avs_write & avs_address;
    assign tx_load     = bitrvs_q ? rev8(avs_writedata[7:0]) : avs_writedata[7:0];
    assign edge_d      = edge_q + 5'd1;
    // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign sample_edge = edge_d[0] ^ mode_q[0];
    assign rx_shift    = {rx_q[6:0], spi_miso};
    assign rx_final    = sample_edge ? rx_shift : rx_q;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            select_q <= 1'b0;
            irqena_q <= 1'b0;
            bitrvs_q <= DEFAULT_REG_BITRVS;
            mode_q   <= DEFAULT_REG_MODE;
            clkdiv_q <= DEFAULT_REG_CLKDIV;
            rxdata_q <= 8'd0;
            div_q    <= 8'd0;
            tx_q     <= 8'd0;
            rx_q     <= 8'd0;
            edge_q   <= 5'd0;
            sclk_q   <= DEFAULT_REG_MODE[1];
            mosi_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_q <= mode_q[1];
                    if (wr1) begin
                        bitrvs_q <= avs_writedata[15];
                        mode_q   <= avs_writedata[13:12];
                        clkdiv_q <= avs_writedata[7:0];
                        sclk_q   <= avs_writedata[13];
                    end
                    if (wr0) begin
                        irqena_q <= avs_writedata[15];
                        select_q <= avs_writedata[8];
                        if (avs_writedata[9]) begin
                            // CPHA=0 puts the first bit out immediately; CPHA=1 waits for edge 1.
                            if (!mode_q[0]) begin
                                mosi_q <= tx_load[7];
                                tx_q   <= {tx_load[6:0], 1'b0};
                            end else begin
                                tx_q   <= tx_load;
                            end
                            div_q   <= clkdiv_q;
                            edge_q  <= 5'd0;
                            ready_q <= 1'b0;
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (div_q == 8'd0) begin
                        div_q  <= clkdiv_q;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_d;
                        if (sample_edge) begin
                            rx_q <= rx_shift;
                        end else begin
                            mosi_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                        if (edge_d == 5'd16) begin
                            rxdata_q <= bitrvs_q ? rev8(rx_final) : rx_final;
                            ready_q  <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        avs_readdata = 32'd0;
        if (!avs_address)
            avs_readdata = {16'd0, irqena_q, 5'd0, ready_q, select_q, rxdata_q};
        else
            avs_readdata = {16'd0, bitrvs_q, 1'b0, mode_q, 4'd0, clkdiv_q};
    end

    assign ins_irq  = irqena_q & ready_q;
    assign spi_ss_n = ~select_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, avs_read, avs_writedata[31:16], avs_writedata[14],
                         avs_writedata[11:10]};
endmodule

// File: tb/tb_peridot_spiflash_byte_master.sv
// Directed bench for the SPI byte master: loopback and slave-model transfers,
// busy-write lockout, interrupt level and asynchronous reset.
module tb_peridot_spiflash_byte_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        avs_address = 1'b0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        ins_irq, spi_ss_n, spi_sclk, spi_mosi, spi_miso;

    int checks = 0;
    int errors = 0;

    logic       loop_en = 1'b1;
    logic [7:0] slave_byte = 8'd0;
    int         slave_base = 0;
    int         neg_cnt = 0;
    int         mon_cnt = 0;
    logic [7:0] mon_bits = 8'd0;
    int         d;
    logic       slave_bit;

    peridot_spiflash_byte_master dut (
        .csi_clk      (clk),
        .rsi_reset_n  (rst_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .ins_irq      (ins_irq),
        .spi_ss_n     (spi_ss_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso)
    );

    always #5 clk = ~clk;

    // MOSI as seen by a slave sampling on SCLK rising (modes 0 and 3).
    always @(posedge spi_sclk) begin
        mon_bits = {mon_bits[6:0], spi_mosi};
        mon_cnt  = mon_cnt + 1;
    end
    always @(negedge spi_sclk) neg_cnt = neg_cnt + 1;

    // Mode-3 slave: bit k appears after the k-th falling (leading) edge.
    always_comb begin
        d = neg_cnt - slave_base;
        slave_bit = 1'b0;
        if (d >= 1 && d <= 8) slave_bit = slave_byte[8-d];
    end
    assign spi_miso = loop_en ? spi_mosi : slave_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic wr(input logic addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write   = 1'b0;
        avs_address = 1'b0;
    endtask

    task automatic rd(input logic addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        #1;
        data        = avs_readdata;
        avs_read    = 1'b0;
        avs_address = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        avs_address = 1'b0;
        while (avs_readdata[9] !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 4000) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int cyc, base;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg0", avs_readdata, 32'h0000_0200);
        chk("rst_ssn", {31'd0, spi_ss_n}, 32'd1);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_irq", {31'd0, ins_irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: mode 0, N=0, loopback, 0xA5
        loop_en = 1'b1;
        base = mon_cnt;
        wr(1'b0, 32'h0000_03A5);
        chk("t1_ssn", {31'd0, spi_ss_n}, 32'd0);
        chk("t1_mosi_first", {31'd0, spi_mosi}, 32'd1);
        wait_ready(cyc);
        chk("t1_busy_cycles", cyc, 32'd16);
        chk("t1_pulses", mon_cnt - base, 32'd8);
        chk("t1_mosi_bits", {24'd0, mon_bits}, 32'h0000_00A5);
        rd(1'b0, r);
        chk("t1_reg0", r, 32'h0000_03A5);

        // 2: mode 3, N=3, slave returns 0x3C, tx 0xFF
        loop_en = 1'b0;
        wr(1'b1, 32'h0000_3003);
        chk("t2_idle_sclk", {31'd0, spi_sclk}, 32'd1);
        rd(1'b1, r);
        chk("t2_reg1", r, 32'h0000_3003);
        slave_byte = 8'h3C;
        slave_base = neg_cnt;
        base = mon_cnt;
        wr(1'b0, 32'h0000_03FF);
        wait_ready(cyc);
        chk("t2_busy_cycles", cyc, 32'd64);
        chk("t2_pulses", mon_cnt - base, 32'd8);
        chk("t2_mosi_bits", {24'd0, mon_bits}, 32'h0000_00FF);
        chk("t2_end_sclk", {31'd0, spi_sclk}, 32'd1);
        rd(1'b0, r);
        chk("t2_reg0", r, 32'h0000_033C);

        // 3: LSB first, tx 0x01, loopback
        loop_en = 1'b1;
        wr(1'b1, 32'h0000_8000);
        chk("t3_idle_sclk", {31'd0, spi_sclk}, 32'd0);
        base = mon_cnt;
        wr(1'b0, 32'h0000_0301);
        wait_ready(cyc);
        chk("t3_busy_cycles", cyc, 32'd16);
        chk("t3_mosi_bits", {24'd0, mon_bits}, 32'h0000_0080);
        rd(1'b0, r);
        chk("t3_reg0", r, 32'h0000_0301);

        // 4: writes while busy are ignored
        wr(1'b1, 32'h0000_0001);
        base = mon_cnt;
        wr(1'b0, 32'h0000_03A5);
        wr(1'b0, 32'h0000_0000);
        chk("t4_ssn_mid", {31'd0, spi_ss_n}, 32'd0);
        wr(1'b1, 32'h0000_3000);
        wait_ready(cyc);
        chk("t4_ssn_end", {31'd0, spi_ss_n}, 32'd0);
        chk("t4_pulses", mon_cnt - base, 32'd8);
        rd(1'b1, r);
        chk("t4_reg1", r, 32'h0000_0001);
        rd(1'b0, r);
        chk("t4_reg0", r, 32'h0000_03A5);
        chk("t4_end_sclk", {31'd0, spi_sclk}, 32'd0);

        // 5: interrupt level
        wr(1'b1, 32'h0000_0000);
        wr(1'b0, 32'h0000_835A);
        chk("t5_irq_busy", {31'd0, ins_irq}, 32'd0);
        wait_ready(cyc);
        chk("t5_irq_done", {31'd0, ins_irq}, 32'd1);
        rd(1'b0, r);
        chk("t5_reg0", r, 32'h0000_835A);
        wr(1'b0, 32'h0000_0100);
        chk("t5_irq_clear", {31'd0, ins_irq}, 32'd0);

        // 6: reset mid-transfer
        wr(1'b1, 32'h0000_0003);
        wr(1'b0, 32'h0000_8377);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ssn", {31'd0, spi_ss_n}, 32'd1);
        chk("t6_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("t6_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("t6_irq", {31'd0, ins_irq}, 32'd0);
        rd(1'b0, r);
        chk("t6_reg0", r, 32'h0000_0200);
        rd(1'b1, r);
        chk("t6_reg1", r, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
